xm23_alu: RTL and testbench

XM23_ALU -- requirements
Module: xm23_alu

---
 rtl/xm23_alu.sv | 212 +++++++++++++++++++++
 tb/tb_xm23_alu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/xm23_alu.sv
// XM23 ALU: one-cycle registered datapath for the arithmetic, BCD, logic, shift and byte ops.
// The PSW is recomputed every cycle, and only C, Z, N and V can change.
module xm23_alu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_d_bus,
  input  logic [15:0] i_s_bus,
  input  logic [5:0]  i_alu_op,
  input  logic [15:0] i_psw_in,
  input  logic        i_psw_update,
  output logic [15:0] o_alu_out,
  output logic [15:0] o_psw_out
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,  OP_SUBC = 5'd3,
    OP_DADD = 5'd4,  OP_CMP  = 5'd5,  OP_XOR  = 5'd6,  OP_AND  = 5'd7,
    OP_OR   = 5'd8,  OP_BIT  = 5'd9,  OP_BIC  = 5'd10, OP_BIS  = 5'd11,
    OP_MOV  = 5'd12, OP_SRA  = 5'd13, OP_RRC  = 5'd14, OP_SWPB = 5'd15,
    OP_SXT  = 5'd16
  } alu_op_e;

  alu_op_e     w_op;
  logic        w_byte;
  logic        w_cIn;
  logic        w_isSub;
  logic [15:0] w_addB;
  logic        w_addCin;
  logic [16:0] w_sumW;
  logic [8:0]  w_sumB;
  logic [15:0] w_addRes;
  logic        w_addC;
  logic        w_addV;
  logic [15:0] w_bcdRes;
  logic        w_bcdCarry;
  logic [4:0]  w_nibSum;
  logic [15:0] w_result;
  logic [15:0] w_flagRes;
  logic        w_c;
  logic        w_v;
  logic        w_z;
  logic        w_n;
  logic        w_updC;
  logic        w_updZN;
  logic        w_updV;
  logic        w_wordOnly;
  logic        w_byteFlags;
  logic [15:0] w_pswNext;
  logic [15:0] r_aluOut;
  logic [15:0] r_psw;

  // In byte mode the upper byte of D passes through untouched.
  function automatic logic [15:0] laneMerge(input logic byteMode, input logic [15:0] dHi,
                                            input logic [15:0] res);
    return byteMode ? {dHi[15:8], res[7:0]} : res;
  endfunction

  assign w_op   = alu_op_e'(i_alu_op[4:0]);
  assign w_byte = i_alu_op[5];
  assign w_cIn  = i_psw_in[0];

  always_comb begin
    w_isSub  = (w_op == OP_SUB) || (w_op == OP_SUBC) || (w_op == OP_CMP);
    w_addB   = w_isSub ? ~i_s_bus : i_s_bus;
    w_addCin = 1'b0;
    case (w_op)
      OP_ADDC, OP_SUBC: w_addCin = w_cIn;
      OP_SUB, OP_CMP:   w_addCin = 1'b1;
      default:          w_addCin = 1'b0;
    endcase
    w_sumW = {1'b0, i_d_bus} + {1'b0, w_addB} + {16'd0, w_addCin};
    w_sumB = {1'b0, i_d_bus[7:0]} + {1'b0, w_addB[7:0]} + {8'd0, w_addCin};
    if (w_byte) begin
      w_addRes = {i_d_bus[15:8], w_sumB[7:0]};
      w_addC   = w_sumB[8];
      w_addV   = (i_d_bus[7] == w_addB[7]) && (w_sumB[7] != i_d_bus[7]);
    end else begin
      w_addRes = w_sumW[15:0];
      w_addC   = w_sumW[16];
      w_addV   = (i_d_bus[15] == w_addB[15]) && (w_sumW[15] != i_d_bus[15]);
    end
  end

  // Ripple BCD adder; a corrected digit is sum-10, done here as +6 modulo 16.
  always_comb begin
    w_bcdRes   = i_d_bus;
    w_bcdCarry = w_cIn;
    w_nibSum   = 5'd0;
    for (int n = 0; n < 4; n++) begin
      if (!w_byte || n < 2) begin
        w_nibSum = {1'b0, i_d_bus[n*4 +: 4]} + {1'b0, i_s_bus[n*4 +: 4]} + {4'd0, w_bcdCarry};
        if (w_nibSum > 5'd9) begin
          w_bcdRes[n*4 +: 4] = w_nibSum[3:0] + 4'd6;
          w_bcdCarry         = 1'b1;
        end else begin
          w_bcdRes[n*4 +: 4] = w_nibSum[3:0];
          w_bcdCarry         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_result   = i_d_bus;
    w_flagRes  = i_d_bus;
    w_c        = w_cIn;
    w_v        = i_psw_in[4];
    w_updC     = 1'b0;
    w_updZN    = 1'b0;
    w_updV     = 1'b0;
    w_wordOnly = 1'b0;
    case (w_op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        w_result  = (w_op == OP_CMP) ? i_d_bus : w_addRes;
        w_flagRes = w_addRes;
        w_c       = w_addC;
        w_v       = w_addV;
        w_updC    = 1'b1;
        w_updZN   = 1'b1;
        w_updV    = 1'b1;
      end
      OP_DADD: begin
        w_result  = w_bcdRes;
        w_flagRes = w_bcdRes;
        w_c       = w_bcdCarry;
        w_updC    = 1'b1;
        w_updZN   = 1'b1;
      end
      OP_XOR: begin
        w_result  = laneMerge(w_byte, i_d_bus, i_d_bus ^ i_s_bus);
        w_flagRes = w_result;
        w_updZN   = 1'b1;
      end
      OP_AND: begin
        w_result  = laneMerge(w_byte, i_d_bus, i_d_bus & i_s_bus);
        w_flagRes = w_result;
        w_updZN   = 1'b1;
      end
      OP_OR, OP_BIS: begin
        w_result  = laneMerge(w_byte, i_d_bus, i_d_bus | i_s_bus);
        w_flagRes = w_result;
        w_updZN   = 1'b1;
      end
      OP_BIT: begin
        w_flagRes = laneMerge(w_byte, i_d_bus, i_d_bus & i_s_bus);
        w_updZN   = 1'b1;
      end
      OP_BIC: begin
        w_result  = laneMerge(w_byte, i_d_bus, i_d_bus & ~i_s_bus);
        w_flagRes = w_result;
        w_updZN   = 1'b1;
      end
      OP_MOV: begin
        w_result  = laneMerge(w_byte, i_d_bus, i_s_bus);
      end
      OP_SRA, OP_RRC: begin
        if (w_byte)
          w_result = {i_d_bus[15:8], (w_op == OP_SRA) ? i_d_bus[7] : w_cIn, i_d_bus[7:1]};
        else
          w_result = {(w_op == OP_SRA) ? i_d_bus[15] : w_cIn, i_d_bus[15:1]};
        w_flagRes = w_result;
        w_c       = i_d_bus[0];
        w_updC    = 1'b1;
        w_updZN   = 1'b1;
      end
      OP_SWPB: begin
        w_result   = {i_d_bus[7:0], i_d_bus[15:8]};
        w_flagRes  = w_result;
        w_updZN    = 1'b1;
        w_wordOnly = 1'b1;
      end
      OP_SXT: begin
        w_result   = {{8{i_d_bus[7]}}, i_d_bus[7:0]};
        w_flagRes  = w_result;
        w_updZN    = 1'b1;
        w_wordOnly = 1'b1;
      end
      default: begin
        w_result = i_d_bus;
      end
    endcase
  end

  always_comb begin
    w_byteFlags = w_byte && !w_wordOnly;
    w_z         = w_byteFlags ? (w_flagRes[7:0] == 8'd0) : (w_flagRes == 16'd0);
    w_n         = w_byteFlags ? w_flagRes[7] : w_flagRes[15];
    w_pswNext   = i_psw_in;
    if (i_psw_update) begin
      if (w_updC) w_pswNext[0] = w_c;
      if (w_updZN) begin
        w_pswNext[1] = w_z;
        w_pswNext[2] = w_n;
      end
      if (w_updV) w_pswNext[4] = w_v;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_aluOut <= 16'h0000;
      r_psw    <= 16'h0000;
    end else begin
      r_aluOut <= w_result;
      r_psw    <= w_pswNext;
    end
  end

  assign o_alu_out = r_aluOut;
  assign o_psw_out = r_psw;

endmodule

// File: tb/tb_xm23_alu.sv
// Scoreboard bench for xm23_alu: directed vectors push expected results, and a monitor
// compares them one cycle later. Reset behaviour is checked directly.
module tb_xm23_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dBus = 16'h0000;
  logic [15:0] sBus = 16'h0000;
  logic [5:0]  aluOp = 6'h00;
  logic [15:0] pswIn = 16'h0000;
  logic        pswUpdate = 1'b0;
  logic [15:0] aluOut;
  logic [15:0] pswOut;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] psw;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  xm23_alu dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_d_bus      (dBus),
    .i_s_bus      (sBus),
    .i_alu_op     (aluOp),
    .i_psw_in     (pswIn),
    .i_psw_update (pswUpdate),
    .o_alu_out    (aluOut),
    .o_psw_out    (pswOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actAlu, input logic [15:0] actPsw,
                             input logic [15:0] expAlu, input logic [15:0] expPsw);
    checks++;
    if (actAlu !== expAlu || actPsw !== expPsw) begin
      failures++;
      $display("[TB] FAIL %s: got alu_out=%h psw_out=%h, expected alu_out=%h psw_out=%h",
               name, actAlu, actPsw, expAlu, expPsw);
    end
  endtask

  task automatic driveInputs(input logic [5:0] op, input logic [15:0] d, input logic [15:0] s,
                             input logic [15:0] psw, input logic upd);
    aluOp     = op;
    dBus      = d;
    sBus      = s;
    pswIn     = psw;
    pswUpdate = upd;
  endtask

  task automatic applyStimulus(input string name, input logic [5:0] op, input logic [15:0] d,
                               input logic [15:0] s, input logic [15:0] psw, input logic upd,
                               input logic [15:0] expAlu, input logic [15:0] expPsw);
    exp_t e;
    @(negedge clk);
    driveInputs(op, d, s, psw, upd);
    e.alu  = expAlu;
    e.psw  = expPsw;
    e.name = name;
    expQ.push_back(e);
  endtask

  // Monitor: the result for the vector driven at a negedge appears after the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.name, aluOut, pswOut, e.alu, e.psw);
      end
    end
  end

  initial begin
    driveInputs(6'h00, 16'h1234, 16'h1111, 16'hFFFF, 1'b1);
    #2 rst = 1'b1;
    #1 checkOutput("reset_async", aluOut, pswOut, 16'h0000, 16'h0000);
    @(posedge clk);
    #1 checkOutput("reset_hold", aluOut, pswOut, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    //            name          op     D        S        psw_in   upd   alu_out  psw_out
    applyStimulus("add_ovf",    6'h00, 16'h7FFF, 16'h0001, 16'h60E0, 1'b1, 16'h8000, 16'h60F4);
    applyStimulus("sub_byte",   6'h22, 16'h1234, 16'h0034, 16'h0000, 1'b1, 16'h1200, 16'h0003);
    applyStimulus("dadd_9999",  6'h04, 16'h9999, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0003);
    applyStimulus("dadd_19_28", 6'h04, 16'h0019, 16'h0028, 16'h0000, 1'b1, 16'h0047, 16'h0000);
    applyStimulus("rrc_word",   6'h0E, 16'h0001, 16'h0000, 16'h0001, 1'b1, 16'h8000, 16'h0005);
    applyStimulus("cmp_noupd",  6'h05, 16'h0005, 16'h0007, 16'h1234, 1'b0, 16'h0005, 16'h1234);
    applyStimulus("add_noupd",  6'h00, 16'h0001, 16'h0001, 16'hABCD, 1'b0, 16'h0002, 16'hABCD);
    applyStimulus("addc_opq",   6'h01, 16'h00FF, 16'h0001, 16'hFFE9, 1'b1, 16'h0101, 16'hFFE8);
    applyStimulus("subc_borr",  6'h03, 16'h0000, 16'h0001, 16'h0000, 1'b1, 16'hFFFE, 16'h0004);
    applyStimulus("sub_ovf",    6'h02, 16'h8000, 16'h0001, 16'h0000, 1'b1, 16'h7FFF, 16'h0011);
    applyStimulus("add_carry",  6'h00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0003);
    applyStimulus("xor_zero",   6'h06, 16'hF0F0, 16'hF0F0, 16'h0011, 1'b1, 16'h0000, 16'h0013);
    applyStimulus("and_byte",   6'h27, 16'hAB80, 16'h12FF, 16'h0000, 1'b1, 16'hAB80, 16'h0004);
    applyStimulus("or_word",    6'h08, 16'h8000, 16'h0001, 16'h0000, 1'b1, 16'h8001, 16'h0004);
    applyStimulus("bit_word",   6'h09, 16'h00F0, 16'h000F, 16'h0005, 1'b1, 16'h00F0, 16'h0003);
    applyStimulus("bic_word",   6'h0A, 16'hFFFF, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 16'h0004);
    applyStimulus("bis_byte",   6'h2B, 16'h1200, 16'hFF81, 16'h0000, 1'b1, 16'h1281, 16'h0004);
    applyStimulus("mov_word",   6'h0C, 16'h1111, 16'hABCD, 16'h0010, 1'b1, 16'hABCD, 16'h0010);
    applyStimulus("sra_byte",   6'h2D, 16'h5581, 16'h0000, 16'h0010, 1'b1, 16'h55C0, 16'h0015);
    applyStimulus("swpb_wb1",   6'h2F, 16'h1280, 16'h0000, 16'h0011, 1'b1, 16'h8012, 16'h0015);
    applyStimulus("sxt_word",   6'h10, 16'h1280, 16'h0000, 16'h0000, 1'b1, 16'hFF80, 16'h0004);
    applyStimulus("dadd_byte",  6'h24, 16'hAB95, 16'h0007, 16'h0001, 1'b1, 16'hAB03, 16'h0001);
    applyStimulus("rrc_byte",   6'h2E, 16'h3402, 16'h0000, 16'h0000, 1'b1, 16'h3401, 16'h0000);
    applyStimulus("op_unused",  6'h11, 16'h4321, 16'hFFFF, 16'h1234, 1'b1, 16'h4321, 16'h1234);
    applyStimulus("add_prerst", 6'h00, 16'h0003, 16'h0004, 16'h0000, 1'b1, 16'h0007, 16'h0000);

    // Pulse reset between edges, then drive an op that must be discarded while reset holds.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput("reset_mid_async", aluOut, pswOut, 16'h0000, 16'h0000);
    @(negedge clk);
    driveInputs(6'h02, 16'h0009, 16'h0001, 16'h00E0, 1'b1);
    @(posedge clk);
    #1 checkOutput("reset_discard", aluOut, pswOut, 16'h0000, 16'h0000);
    #2 rst = 1'b0;
    applyStimulus("post_reset", 6'h00, 16'h1000, 16'h0234, 16'h0020, 1'b1, 16'h1234, 16'h0020);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
